av_fft_loader: RTL and testbench
================================

// Module: av_fft_loader
// PURPOSE
//  Parametrised Avalon-MM slave: host loads FFT input samples into one of N_CH sample buffers,
//  then the block pulses fft_start for that channel and tracks completion via fft_done.
//  Command/status registers sit above the sample window. Sits between the HPS/Avalon fabric
//  and the multi-channel FFT sample RAM and core.
// PARAMETERS
//  DATA_W     16   sample width; writedata[DATA_W-1:0] forwarded to RAM
//  N_SAMPLES  512  samples per channel; sample window = addresses 0..N_SAMPLES-1
//  N_CH       4    number of channel buffers; CH_W = max(1,$clog2(N_CH))
//  ADDR_W     10   Avalon word-address width; must hold N_SAMPLES+1
//  AUTO_START 1    1: start FFT automatically when N_SAMPLES writes received; 0: only on GO
// PORTS
//  clk               in   1       clock
//  rst               in   1       synchronous, active-high reset
//  slave_chipselect  in   1       Avalon chipselect
//  slave_write       in   1       Avalon write strobe
//  slave_read        in   1       Avalon read strobe
//  slave_address     in   ADDR_W  word address
//  slave_writedata   in   32      write data
//  slave_readdata    out  32      read data, fixed 1-cycle read latency
//  mem_we            out  1       sample RAM write enable (registered)
//  mem_addr          out  ADDR_W  sample index 0..N_SAMPLES-1
//  mem_ch            out  CH_W    target channel buffer
//  mem_data          out  DATA_W  sample value
//  fft_start         out  1       one-cycle start pulse
//  fft_ch            out  CH_W    channel to transform, valid while busy
//  fft_done          in   1       FFT completion pulse (honoured only in RUN)
// BEHAVIOUR
//  Map: CMD_ADDR=N_SAMPLES (W), STAT_ADDR=N_SAMPLES+1 (R). Other addresses: writes dropped, reads 0.
//  CMD opcode writedata[3:0]: 1=ARM (channel in writedata[15:8]), 2=GO, 3=ABORT; others ignored.
//  Reset: state IDLE; all outputs 0; count=0; done/err/ovr flags 0; channel reg 0.
//  FSM IDLE: ARM with ch<N_CH -> LOAD, count=0, latch ch, clear done; ch>=N_CH -> set err, stay.
//  FSM LOAD: sample write -> next cycle mem_we=1 with addr/ch/data, count++ (saturates N_SAMPLES).
//    AUTO_START=1 and write brings count to N_SAMPLES -> START (RAM write still issued same edge).
//    GO -> START (partial load legal). ABORT -> IDLE, no start. ARM ignored.
//  FSM START: fft_start=1 exactly one cycle -> RUN. fft_ch = latched ch.
//  FSM RUN: fft_done -> IDLE, set done. ABORT -> IDLE, no done. Sample writes dropped.
//  Sample write outside LOAD: no mem_we, set ovr sticky. GO outside LOAD: ignored.
//  fft_done outside RUN ignored. Writes and reads never overlap (Avalon master guarantees).
//  STATUS: [0]=busy(state!=IDLE) [1]=done [2]=err [3]=ovr [5:4]=state(0..3)
//    [15:8]=latched ch [31:16]=count. Read of STATUS clears done/err/ovr after data captured.
//  Read: slave_readdata valid cycle after chipselect&read; holds until next read.
//  mem_we is a 1-cycle pulse per accepted write; latency write->RAM = 1 clk.
//  Reset mid-operation: any state -> IDLE next edge, pending mem_we/fft_start suppressed.
// TESTING
//  Reset then read STATUS -> readdata 0x00000000; mem_we, fft_start 0.
//  ARM ch=2, write 512 samples (addr i, data i*3) -> 512 mem_we pulses, mem_ch=2; fft_start 1 clk
//   after last write; STATUS busy=1,state=RUN,count=512.
//  In RUN, pulse fft_done -> IDLE; STATUS done=1; second STATUS read done=0.
//  ARM ch=1, 10 writes, GO -> fft_start with count=10; ABORT in LOAD -> no fft_start.
//  Write sample in IDLE -> no mem_we, ovr=1; ARM ch=7 (N_CH=4) -> stay IDLE, err=1.
//  Assert rst in RUN and mid-load -> next cycle state IDLE, all outputs 0, count 0.

Source files
------------

// File: rtl/av_fft_loader.sv
// Avalon-MM loader: streams host sample writes into per-channel FFT RAM, then starts and tracks the FFT.
// Sample write -> mem_we after 1 clk; STATUS read data after 1 clk; no waitrequest, so accepted writes are never stalled.
module av_fft_loader #(
  parameter int DATA_W     = 16,
  parameter int N_SAMPLES  = 512,
  parameter int N_CH       = 4,
  parameter int ADDR_W     = 10,
  parameter int AUTO_START = 1,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slave_chipselect,
  input  logic              slave_write,
  input  logic              slave_read,
  input  logic [ADDR_W-1:0] slave_address,
  input  logic [31:0]       slave_writedata,
  output logic [31:0]       slave_readdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CH_W-1:0]   mem_ch,
  output logic [DATA_W-1:0] mem_data,
  output logic              fft_start,
  output logic [CH_W-1:0]   fft_ch,
  input  logic              fft_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(N_SAMPLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(N_SAMPLES);
  localparam logic [ADDR_W-1:0] CMD_ADDR  = ADDR_W'(N_SAMPLES);
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(N_SAMPLES + 1);
  localparam logic [7:0]        N_CH_B    = 8'(N_CH);
  localparam logic [3:0] OP_ARM = 4'd1, OP_GO = 4'd2, OP_ABORT = 4'd3;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [CH_W-1:0]  ch_q;
  logic             done_q, err_q, ovr_q;

  logic       wr_en, rd_en, samp_wr, cmd_wr, stat_rd;
  logic [3:0] opcode;
  logic [7:0] arm_ch;
  logic       arm_ok, arm_bad, samp_acc, ovr_set, done_set;
  logic       unused_wd;

  assign wr_en     = slave_chipselect & slave_write;
  assign rd_en     = slave_chipselect & slave_read;
  assign samp_wr   = wr_en && (slave_address < CMD_ADDR);
  assign cmd_wr    = wr_en && (slave_address == CMD_ADDR);
  assign stat_rd   = rd_en && (slave_address == STAT_ADDR);
  assign opcode    = slave_writedata[3:0];
  assign arm_ch    = slave_writedata[15:8];
  assign fft_ch    = ch_q;
  assign unused_wd = ^slave_writedata;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    arm_ok    = 1'b0;
    arm_bad   = 1'b0;
    samp_acc  = 1'b0;
    done_set  = 1'b0;
    fft_start = 1'b0;
    ovr_set   = samp_wr && (state_q != S_LOAD);
    case (state_q)
      S_IDLE: begin
        if (cmd_wr && opcode == OP_ARM) begin
          if (arm_ch < N_CH_B) begin
            arm_ok  = 1'b1;
            state_d = S_LOAD;
          end else begin
            arm_bad = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (samp_wr) begin
          samp_acc = 1'b1;
          if (AUTO_START != 0 && count_q == CNT_MAX - 1'b1) state_d = S_START;
        end
        if (cmd_wr && opcode == OP_GO)    state_d = S_START;
        if (cmd_wr && opcode == OP_ABORT) state_d = S_IDLE;
      end
      S_START: begin
        fft_start = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        // A completion that lands with an ABORT still counts as done.
        if (fft_done) begin
          done_set = 1'b1;
          state_d  = S_IDLE;
        end else if (cmd_wr && opcode == OP_ABORT) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q        <= '0;
      ch_q           <= '0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      ovr_q          <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_ch         <= '0;
      mem_data       <= '0;
      slave_readdata <= '0;
    end else begin
      mem_we <= samp_acc;
      if (samp_acc) begin
        mem_addr <= slave_address;
        mem_ch   <= ch_q;
        mem_data <= slave_writedata[DATA_W-1:0];
        if (count_q != CNT_MAX) count_q <= count_q + 1'b1;
      end
      if (arm_ok) begin
        ch_q    <= arm_ch[CH_W-1:0];
        count_q <= '0;
        done_q  <= 1'b0;
      end
      if (rd_en) begin
        slave_readdata <= stat_rd ? {16'(count_q), 8'(ch_q), 2'b00, state_q,
                                     ovr_q, err_q, done_q, state_q != S_IDLE}
                                  : 32'd0;
      end
      // Clear-on-read first so a set arriving in the same cycle is not lost.
      if (stat_rd) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
        ovr_q  <= 1'b0;
      end
      if (done_set) done_q <= 1'b1;
      if (arm_bad)  err_q  <= 1'b1;
      if (ovr_set)  ovr_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_av_fft_loader.sv
// Directed bench for av_fft_loader with default parameters (512 samples, 4 channels, auto start).
module tb_av_fft_loader;

  localparam int ADDR_W = 10;
  localparam logic [ADDR_W-1:0] CMD  = 10'd512;
  localparam logic [ADDR_W-1:0] STAT = 10'd513;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs, wr, rd, fft_done;
  logic [ADDR_W-1:0] addr;
  logic [31:0] wdata, rdata;
  logic        mem_we, fft_start;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]  mem_ch, fft_ch;
  logic [15:0] mem_data;

  int passed = 0;
  int total  = 0;
  int we_cnt = 0;
  int start_cnt = 0;

  av_fft_loader dut (
    .clk              (clk),
    .rst              (rst),
    .slave_chipselect (cs),
    .slave_write      (wr),
    .slave_read       (rd),
    .slave_address    (addr),
    .slave_writedata  (wdata),
    .slave_readdata   (rdata),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_ch           (mem_ch),
    .mem_data         (mem_data),
    .fft_start        (fft_start),
    .fft_ch           (fft_ch),
    .fft_done         (fft_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we)    we_cnt    <= we_cnt + 1;
    if (fft_start) start_cnt <= start_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Each access occupies one rising edge; returns at the following falling edge.
  task automatic av_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic av_rd(input logic [ADDR_W-1:0] a);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
  endtask

  initial begin
    int bad;
    int sbase, wbase;
    rst = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; fft_done = 1'b0;
    addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_fft_start", {31'd0, fft_start}, 32'd0);
    av_rd(STAT);
    chk("rst_status", rdata, 32'h0000_0000);

    // Full auto-started load on channel 2
    av_wr(CMD, 32'h0000_0201);
    wbase = we_cnt; sbase = start_cnt; bad = 0;
    for (int i = 0; i < 512; i++) begin
      av_wr(ADDR_W'(i), 32'(i * 3));
      if (!(mem_we === 1'b1 && mem_addr === ADDR_W'(i) &&
            mem_data === 16'(i * 3) && mem_ch === 2'd2)) bad++;
      if (i < 511 && fft_start !== 1'b0) bad++;
    end
    chk("load512_beats", bad, 0);
    chk("load512_start_pulse", {31'd0, fft_start}, 32'd1);
    chk("load512_fft_ch", {30'd0, fft_ch}, 32'd2);
    @(negedge clk);
    chk("load512_start_one_cycle", {31'd0, fft_start}, 32'd0);
    chk("load512_we_count", we_cnt - wbase, 512);
    chk("load512_start_count", start_cnt - sbase, 1);
    av_rd(STAT);
    chk("run_status", rdata, 32'h0200_0231);

    @(negedge clk); fft_done = 1'b1;
    @(negedge clk); fft_done = 1'b0;
    av_rd(STAT);
    chk("done_status", rdata, 32'h0200_0202);
    av_rd(STAT);
    chk("done_cleared", rdata, 32'h0200_0200);

    // Partial load on channel 1, started by GO, then aborted in RUN
    av_wr(CMD, 32'h0000_0101);
    av_rd(STAT);
    chk("arm1_status", rdata, 32'h0000_0111);
    for (int i = 0; i < 10; i++) av_wr(ADDR_W'(i), 32'(100 + i));
    chk("partial_last_data", {16'd0, mem_data}, 32'd109);
    sbase = start_cnt;
    av_wr(CMD, 32'h0000_0002);
    chk("go_start_pulse", {31'd0, fft_start}, 32'd1);
    chk("go_fft_ch", {30'd0, fft_ch}, 32'd1);
    av_rd(STAT);
    chk("go_run_status", rdata, 32'h000A_0131);
    chk("go_start_count", start_cnt - sbase, 1);
    av_wr(CMD, 32'h0000_0003);
    av_rd(STAT);
    chk("abort_run_status", rdata, 32'h000A_0100);

    // ABORT during LOAD never starts the FFT
    av_wr(CMD, 32'h0000_0301);
    for (int i = 0; i < 5; i++) av_wr(ADDR_W'(i), 32'(i));
    sbase = start_cnt;
    av_wr(CMD, 32'h0000_0003);
    repeat (4) @(negedge clk);
    chk("abort_load_no_start", start_cnt - sbase, 0);
    av_rd(STAT);
    chk("abort_load_status", rdata, 32'h0005_0300);

    // Sample write in IDLE sets ovr, bad channel sets err, GO in IDLE ignored
    wbase = we_cnt;
    av_wr(10'd7, 32'h0000_0055);
    chk("idle_write_no_we", {31'd0, mem_we}, 32'd0);
    av_rd(STAT);
    chk("ovr_status", rdata, 32'h0005_0308);
    chk("idle_write_we_count", we_cnt - wbase, 0);
    av_wr(CMD, 32'h0000_0701);
    av_rd(STAT);
    chk("err_status", rdata, 32'h0005_0304);
    av_wr(CMD, 32'h0000_0002);
    chk("idle_go_no_start", {31'd0, fft_start}, 32'd0);
    av_rd(STAT);
    chk("idle_go_status", rdata, 32'h0005_0300);
    av_rd(10'd700);
    chk("unmapped_read", rdata, 32'h0000_0000);

    // Reset coinciding with a LOAD sample write
    av_wr(CMD, 32'h0000_0201);
    av_wr(10'd0, 32'h0000_0011);
    av_wr(10'd1, 32'h0000_0022);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = 10'd2; wdata = 32'h0000_0033; rst = 1'b1;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; rst = 1'b0;
    chk("rst_load_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_load_mem_data", {16'd0, mem_data}, 32'd0);
    chk("rst_load_mem_ch", {30'd0, mem_ch}, 32'd0);
    av_rd(STAT);
    chk("rst_load_status", rdata, 32'h0000_0000);

    // Reset while RUN with ovr pending
    av_wr(CMD, 32'h0000_0101);
    av_wr(10'd0, 32'h0000_0007);
    av_wr(CMD, 32'h0000_0002);
    @(negedge clk);
    av_wr(10'd3, 32'h0000_0009);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_run_fft_start", {31'd0, fft_start}, 32'd0);
    chk("rst_run_fft_ch", {30'd0, fft_ch}, 32'd0);
    chk("rst_run_readdata", rdata, 32'd0);
    av_rd(STAT);
    chk("rst_run_status", rdata, 32'h0000_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
